// File: rtl/xcore_gnrl_pkg.sv
`default_nettype none
// ==== xcore_gnrl_pkg : shared helpers for the xcore_gnrl_* blocks ====
// ==== rev 1.0                                                       ====
package xcore_gnrl_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xcore_gnrl_fifo_ptr.sv
`default_nettype none
// ==== xcore_gnrl_fifo_ptr : wrapping pointer counter with increment enable ====
// ==== rev 1.0                                                              ====
module xcore_gnrl_fifo_ptr
  import xcore_gnrl_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Full-width increment: the MSB acts as the wrap flag.
  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/xcore_gnrl_fifo.sv
`default_nettype none
// ==== xcore_gnrl_fifo : synchronous valid/ready FIFO, register storage ====
// ==== rev 1.0                                                          ====
module xcore_gnrl_fifo
  import xcore_gnrl_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned DP = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_vld,
  output logic                      i_rdy,
  input  logic [DW-1:0]             i_dat,
  output logic                      o_vld,
  input  logic                      o_rdy,
  output logic [DW-1:0]             o_dat,
  output logic [clog2(DP):0]        count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = clog2(DP);

  generate
    if (!is_pow2(DP) || DP < 2 || DW < 1) begin : g_param_bad
      $fatal(1, "xcore_gnrl_fifo: DP must be a power of two >= 2 and DW >= 1");
    end
  endgenerate

  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          wr_fire;
  logic          rd_fire;
  logic [DW-1:0] mem_q [DP];

  assign wr_fire = i_vld & i_rdy;
  assign rd_fire = o_vld & o_rdy;

  xcore_gnrl_fifo_ptr #(.W(AW + 1)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (wr_fire),
    .ptr_o (wptr_q)
  );

  xcore_gnrl_fifo_ptr #(.W(AW + 1)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (rd_fire),
    .ptr_o (rptr_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DP; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DP; i++) begin
        if (wr_fire && (wptr_q[AW-1:0] == AW'(i))) mem_q[i] <= i_dat;
      end
    end
  end

  // Status comes from pointers only, so no input reaches a ready/valid output.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign i_rdy = ~full;
  assign o_vld = ~empty;
  assign o_dat = mem_q[rptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_xcore_gnrl_fifo.sv
`default_nettype none
// ==== tb_xcore_gnrl_fifo : self-checking bench, queue reference model ====
// ==== rev 1.0                                                          ====
module tb_xcore_gnrl_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       i_vld = 1'b0, o_rdy = 1'b0;
  logic [7:0] i_dat = '0;
  logic       i_rdy, o_vld, full, empty;
  logic [7:0] o_dat;
  logic [2:0] count;

  logic       i_vld2 = 1'b0, o_rdy2 = 1'b0;
  logic       i_dat2 = 1'b0;
  logic       i_rdy2, o_vld2, full2, empty2, o_dat2;
  logic [1:0] count2;

  int checks = 0;
  int failures = 0;

  logic [7:0] q1[$];
  logic       q2[$];

  always #5 clk = ~clk;

  xcore_gnrl_fifo #(.DW(8), .DP(4)) u_dut (
    .clk(clk), .reset(reset),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat),
    .count(count), .full(full), .empty(empty)
  );

  xcore_gnrl_fifo #(.DW(1), .DP(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .i_vld(i_vld2), .i_rdy(i_rdy2), .i_dat(i_dat2),
    .o_vld(o_vld2), .o_rdy(o_rdy2), .o_dat(o_dat2),
    .count(count2), .full(full2), .empty(empty2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q1.size()));
    chk({tag, ".o_vld"}, 32'(o_vld), 32'(q1.size() != 0));
    chk({tag, ".empty"}, 32'(empty), 32'(q1.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q1.size() == 4));
    chk({tag, ".i_rdy"}, 32'(i_rdy), 32'(q1.size() != 4));
    if (q1.size() != 0) chk({tag, ".o_dat"}, 32'(o_dat), 32'(q1[0]));
  endtask

  // One clock on the DP=4 instance; the model decides which side fires.
  task automatic step1(input logic v, input logic r, input logic [7:0] d,
                       input string tag, output bit wf, output bit rf);
    i_vld = v; o_rdy = r; i_dat = d;
    wf = v && (q1.size() < 4);
    rf = r && (q1.size() > 0);
    @(posedge clk); #1;
    if (rf) void'(q1.pop_front());
    if (wf) q1.push_back(d);
    cmp1(tag);
  endtask

  task automatic step2(input logic v, input logic r, input logic d, input string tag);
    bit wf, rf;
    i_vld2 = v; o_rdy2 = r; i_dat2 = d;
    wf = v && (q2.size() < 2);
    rf = r && (q2.size() > 0);
    @(posedge clk); #1;
    if (rf) void'(q2.pop_front());
    if (wf) q2.push_back(d);
    chk({tag, ".count"}, 32'(count2), 32'(q2.size()));
    chk({tag, ".full"},  32'(full2),  32'(q2.size() == 2));
    chk({tag, ".o_vld"}, 32'(o_vld2), 32'(q2.size() != 0));
    if (q2.size() != 0) chk({tag, ".o_dat"}, 32'(o_dat2), 32'(q2[0]));
  endtask

  typedef struct {
    logic       vld;
    logic       rdy;
    logic [7:0] dat;
    logic [2:0] e_count;
    logic       e_ovld;
    logic [7:0] e_odat;
    logic       e_full;
  } vec_t;

  initial begin
    vec_t tbl[13];
    bit   wf, rf;
    int   nxt, rx, cyc, msb_toggles;
    logic cur_v;

    tbl[0]  = '{1'b1, 1'b0, 8'h11, 3'd1, 1'b1, 8'h11, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 3'd2, 1'b1, 8'h11, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 3'd3, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h44, 3'd4, 1'b1, 8'h11, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'h55, 3'd4, 1'b1, 8'h11, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'h66, 3'd3, 1'b1, 8'h22, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 8'h33, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 3'd1, 1'b1, 8'h44, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'h44, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'hA0, 3'd1, 1'b1, 8'hA0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'hA1, 3'd1, 1'b1, 8'hA1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'hA1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hA1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full",  32'(full),  32'd0);
    chk("rst.i_rdy", 32'(i_rdy), 32'd1);
    chk("rst.o_vld", 32'(o_vld), 32'd0);
    chk("rst.o_dat", 32'(o_dat), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed table: fill, rejected write, full/empty simultaneous, drain.
    for (int i = 0; i < 13; i++) begin
      step1(tbl[i].vld, tbl[i].rdy, tbl[i].dat, $sformatf("tbl%0d", i), wf, rf);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d.o_vld", i), 32'(o_vld), 32'(tbl[i].e_ovld));
      chk($sformatf("tbl%0d.full", i),  32'(full),  32'(tbl[i].e_full));
      if (tbl[i].e_ovld) chk($sformatf("tbl%0d.o_dat", i), 32'(o_dat), 32'(tbl[i].e_odat));
    end

    // Steady state at count=2 with both sides active.
    step1(1'b1, 1'b0, 8'h30, "pre2a", wf, rf);
    step1(1'b1, 1'b0, 8'h31, "pre2b", wf, rf);
    for (int i = 0; i < 10; i++) begin
      step1(1'b1, 1'b1, 8'(8'h32 + i), $sformatf("both%0d", i), wf, rf);
      chk($sformatf("both%0d.cnt2", i), 32'(count), 32'd2);
    end

    // Asynchronous reset mid-traffic with two entries held.
    i_vld = 1'b1; o_rdy = 1'b0; i_dat = 8'h77;
    #2 reset = 1'b0;
    #1;
    q1.delete(); q2.delete();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.i_rdy", 32'(i_rdy), 32'd1);
    chk("arst.o_vld", 32'(o_vld), 32'd0);
    chk("arst.o_dat", 32'(o_dat), 32'd0);
    i_vld = 1'b0;
    @(negedge clk) reset = 1'b1;
    step1(1'b1, 1'b0, 8'hA5, "post_rst", wf, rf);
    chk("post_rst.o_dat", 32'(o_dat), 32'hA5);
    step1(1'b0, 1'b1, 8'h00, "post_rst_drain", wf, rf);

    // Randomized stream 0x00..0x13 with producer hold rule.
    nxt = 0; rx = 0; cyc = 0; cur_v = 1'b0; msb_toggles = 0;
    while (rx < 20 && cyc < 500) begin
      logic r;
      logic [7:0] head;
      if (!cur_v && nxt < 20) cur_v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1) == 1;
      head = (q1.size() != 0) ? q1[0] : 8'h00;
      step1(cur_v, r, 8'(nxt), "rnd", wf, rf);
      if (rf) begin
        chk("rnd.order", 32'(head), 32'(rx));
        rx++;
      end
      if (wf) begin
        nxt++;
        cur_v = 1'b0;
        if ((nxt % 4) == 0) msb_toggles++;
      end
      chk("rnd.full_and_empty", 32'(full && empty), 32'd0);
      cyc++;
    end
    chk("rnd.received", 32'(rx), 32'd20);
    chk("rnd.wrap_count", 32'(msb_toggles >= 4), 32'd1);
    i_vld = 1'b0; o_rdy = 1'b0;

    // DP=2, DW=1: alternate fill and drain.
    for (int k = 0; k < 2; k++) begin
      step2(1'b1, 1'b0, 1'b1, "d2fill0");
      step2(1'b1, 1'b0, 1'b0, "d2fill1");
      chk("d2.full_at2", 32'(full2 && (count2 == 2'd2)), 32'd1);
      step2(1'b0, 1'b1, 1'b0, "d2drain0");
      step2(1'b0, 1'b1, 1'b0, "d2drain1");
    end
    chk("d2.empty_end", 32'(empty2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
